// File: rtl/gpio_poll_master.sv
// rtl/gpio_poll_master.sv - GPIO bus master: polls buttons, debounces, toggles LEDs on press.
// Sole initiator on the valid/sel/we bus; all bus strobes are registered one-cycle pulses.
module gpio_poll_master #(
  parameter int POLL_DIV = 16,
  parameter int DEB_CNT  = 3,
  parameter int RD_LAT   = 1
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [3:0] data_s,
  output logic       valid,
  output logic       sel_led,
  output logic       sel_but,
  output logic       we,
  output logic [3:0] data_m,
  output logic [3:0] led_o,
  output logic [3:0] btn_o,
  output logic [3:0] press_o,
  output logic       busy_o
);

  localparam int PW = $clog2(POLL_DIV + 1);
  localparam int DW = $clog2(DEB_CNT + 1);
  localparam int RW = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {INIT, IDLE, RD_REQ, RD_WAIT, SAMPLE, WR_REQ} state_t;

  state_t          state;
  logic [PW-1:0]   poll_cnt;
  logic            tick;
  logic [3:0]      last_raw;
  logic [DW-1:0]   deb_cnt;
  logic [RW-1:0]   wait_cnt;
  logic [DW-1:0]   deb_cnt_nxt;
  logic [3:0]      btn_nxt;
  logic [3:0]      press_nxt;

  assign tick = (poll_cnt == PW'(POLL_DIV - 1));

  // Free-running poll divider, parked at zero while polling is disabled.
  always_ff @(posedge clk) begin
    if (rst_i || !en_i) begin
      poll_cnt <= '0;
    end else if (tick) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + PW'(1);
    end
  end

  always_comb begin
    deb_cnt_nxt = deb_cnt;
    if (data_s != last_raw) begin
      deb_cnt_nxt = DW'(1);
    end else if (deb_cnt < DW'(DEB_CNT)) begin
      deb_cnt_nxt = deb_cnt + DW'(1);
    end
    btn_nxt = btn_o;
    if (deb_cnt_nxt == DW'(DEB_CNT)) begin
      btn_nxt = data_s;
    end
    press_nxt = btn_nxt & ~btn_o;
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state    <= INIT;
      valid    <= 1'b0;
      sel_led  <= 1'b0;
      sel_but  <= 1'b0;
      we       <= 1'b0;
      data_m   <= '0;
      led_o    <= '0;
      btn_o    <= '0;
      press_o  <= '0;
      busy_o   <= 1'b1;
      last_raw <= '0;
      deb_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      valid   <= 1'b0;
      sel_led <= 1'b0;
      sel_but <= 1'b0;
      we      <= 1'b0;
      data_m  <= '0;
      press_o <= '0;
      case (state)
        INIT: begin
          // First cycle out of reset drives the LED clear; the next leaves for IDLE.
          if (!valid) begin
            valid   <= 1'b1;
            sel_led <= 1'b1;
            we      <= 1'b1;
            busy_o  <= 1'b1;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        IDLE: begin
          if (tick && en_i) begin
            state   <= RD_REQ;
            valid   <= 1'b1;
            sel_but <= 1'b1;
            busy_o  <= 1'b1;
          end
        end
        RD_REQ: begin
          wait_cnt <= RW'(1);
          state    <= (RD_LAT == 1) ? SAMPLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt >= RW'(RD_LAT - 1)) begin
            state <= SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + RW'(1);
          end
        end
        SAMPLE: begin
          last_raw <= data_s;
          deb_cnt  <= deb_cnt_nxt;
          btn_o    <= btn_nxt;
          press_o  <= press_nxt;
          led_o    <= led_o ^ press_nxt;
          if (press_nxt != 4'd0) begin
            state   <= WR_REQ;
            valid   <= 1'b1;
            sel_led <= 1'b1;
            we      <= 1'b1;
            data_m  <= led_o ^ press_nxt;
          end else begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end
        end
        WR_REQ: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state  <= INIT;
          busy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule
